// File: rtl/tod_pkg.sv
// Shared field widths and wrap limits for the time-of-day counter.
package tod_pkg;
  localparam int SC_W     = 7;
  localparam int MT_W     = 7;
  localparam int HR_W     = 5;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MOD = 12;
endpackage

// File: rtl/modn_cnt.sv
// Generic mod-N wrap counter with synchronous load; tc is the qualified carry-out.
module modn_cnt #(
  parameter int N = 60,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         tc
);
  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Carry only when actually advancing, so it can enable the next stage directly.
  assign tc  = en && (cnt_q == MAX);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = ld_val;
    else if (en) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter: prescaled seconds tick, 24h internal time, 12h/24h display,
// range-checked preset and one-shot hh:mm alarm.
module tod_counter
  import tod_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic            clk_50,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode24,
  input  logic            load,
  input  logic [HR_W-1:0] ld_hr,
  input  logic [MT_W-1:0] ld_mt,
  input  logic [SC_W-1:0] ld_sc,
  input  logic            alarm_en,
  input  logic [HR_W-1:0] al_hr,
  input  logic [MT_W-1:0] al_mt,
  output logic [SC_W-1:0] SC,
  output logic [MT_W-1:0] MT,
  output logic [HR_W-1:0] HR,
  output logic            pm,
  output logic            tick,
  output logic            tc,
  output logic            alarm,
  output logic            load_err
);
  localparam int DIV_W = $clog2(TICK_DIV) + 1;
  localparam logic [DIV_W-1:0] PRE_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] pre_q, pre_d;
  logic tick_int, adv;
  logic [SC_W-1:0] sc, ld_sc_ok;
  logic [MT_W-1:0] mt, ld_mt_ok, mt_nxt;
  logic [HR_W-1:0] hr, ld_hr_ok, hr_nxt;
  logic sc_tc, mt_tc, hr_tc;
  logic bad_sc, bad_mt, bad_hr;
  logic tick_q, tick_d, tc_q, tc_d, alarm_q, alarm_d, lerr_q, lerr_d;

  assign tick_int = en && (pre_q == PRE_MAX);
  // Load pre-empts a coincident tick so a preset is never bumped on arrival.
  assign adv      = tick_int && !load;

  always_comb begin
    pre_d = pre_q;
    if (load)    pre_d = '0;
    else if (en) pre_d = tick_int ? '0 : pre_q + 1'b1;
  end

  assign bad_sc   = ld_sc > SC_W'(SEC_MAX);
  assign bad_mt   = ld_mt > MT_W'(MIN_MAX);
  assign bad_hr   = ld_hr > HR_W'(HR24_MAX);
  assign ld_sc_ok = bad_sc ? '0 : ld_sc;
  assign ld_mt_ok = bad_mt ? '0 : ld_mt;
  assign ld_hr_ok = bad_hr ? '0 : ld_hr;

  modn_cnt #(.N(SEC_MAX + 1), .W(SC_W)) u_sec (
    .clk(clk_50), .rst_n(rst_n), .en(adv), .load(load),
    .ld_val(ld_sc_ok), .cnt(sc), .tc(sc_tc));
  modn_cnt #(.N(MIN_MAX + 1), .W(MT_W)) u_min (
    .clk(clk_50), .rst_n(rst_n), .en(sc_tc), .load(load),
    .ld_val(ld_mt_ok), .cnt(mt), .tc(mt_tc));
  modn_cnt #(.N(HR24_MAX + 1), .W(HR_W)) u_hr (
    .clk(clk_50), .rst_n(rst_n), .en(mt_tc), .load(load),
    .ld_val(ld_hr_ok), .cnt(hr), .tc(hr_tc));

  // Alarm needs sc==0 after the advance, i.e. a seconds wrap; look at post-advance mt/hr.
  assign mt_nxt = mt_tc ? '0 : mt + 1'b1;
  assign hr_nxt = hr_tc ? '0 : (mt_tc ? hr + 1'b1 : hr);

  always_comb begin
    tick_d  = adv;
    tc_d    = hr_tc;
    alarm_d = sc_tc && alarm_en && (mt_nxt == al_mt) && (hr_nxt == al_hr);
    lerr_d  = load && (bad_sc || bad_mt || bad_hr);
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
      alarm_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
      alarm_q <= alarm_d;
      lerr_q  <= lerr_d;
    end
  end

  assign SC       = sc;
  assign MT       = mt;
  assign pm       = hr >= HR_W'(HR12_MOD);
  assign HR       = (mode24 || !pm) ? hr : hr - HR_W'(HR12_MOD);
  assign tick     = tick_q;
  assign tc       = tc_q;
  assign alarm    = alarm_q;
  assign load_err = lerr_q;
endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter: seconds-of-day model checked every cycle plus directed literals.
module tb_tod_counter;
  localparam int TD = 4;

  logic clk_50 = 1'b0;
  logic rst_n, en, mode24, load, alarm_en;
  logic [4:0] ld_hr, al_hr;
  logic [6:0] ld_mt, ld_sc, al_mt;
  logic [6:0] SC, MT;
  logic [4:0] HR;
  logic pm, tick, tc, alarm, load_err;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // model state: time as seconds since midnight
  int m_t = 0, m_p = 0;
  bit m_tick = 0, m_tc = 0, m_alarm = 0, m_lerr = 0;

  tod_counter #(.TICK_DIV(TD)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .en(en), .mode24(mode24), .load(load),
    .ld_hr(ld_hr), .ld_mt(ld_mt), .ld_sc(ld_sc), .alarm_en(alarm_en),
    .al_hr(al_hr), .al_mt(al_mt), .SC(SC), .MT(MT), .HR(HR), .pm(pm),
    .tick(tick), .tc(tc), .alarm(alarm), .load_err(load_err));

  always #5 clk_50 = ~clk_50;

  always @(posedge clk_50) begin
    int s, m, h;
    if (!rst_n) begin
      m_t = 0; m_p = 0; m_tick = 0; m_tc = 0; m_alarm = 0; m_lerr = 0;
    end else begin
      m_tick = 0; m_tc = 0; m_alarm = 0; m_lerr = 0;
      if (load) begin
        s = (ld_sc > 59) ? 0 : int'(ld_sc);
        m = (ld_mt > 59) ? 0 : int'(ld_mt);
        h = (ld_hr > 23) ? 0 : int'(ld_hr);
        m_lerr = (ld_sc > 59) || (ld_mt > 59) || (ld_hr > 23);
        m_t = h * 3600 + m * 60 + s;
        m_p = 0;
      end else if (en) begin
        if (m_p == TD - 1) begin
          m_p = 0;
          m_t = (m_t + 1) % 86400;
          m_tick = 1;
          m_tc = (m_t == 0);
          m_alarm = alarm_en && (m_t == int'(al_hr) * 3600 + int'(al_mt) * 60);
        end else m_p = m_p + 1;
      end
    end
  end

  always @(posedge clk_50) begin
    logic [24:0] got, exp;
    int h;
    #1;
    if (chk_on) begin
      h   = m_t / 3600;
      exp = {7'(m_t % 60), 7'((m_t / 60) % 60), 5'(mode24 ? h : h % 12),
             (h >= 12), m_tick, m_tc, m_alarm, m_lerr};
      got = {SC, MT, HR, pm, tick, tc, alarm, load_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model t=%0t got %h want %h", $time, got, exp);
      end
    end
  end

  task automatic lit(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1; ld_hr = 5'(h); ld_mt = 7'(m); ld_sc = 7'(s);
    cyc(1);
    load = 0;
  endtask

  initial begin
    int nt;
    rst_n = 0; en = 0; mode24 = 1; load = 0; alarm_en = 0;
    ld_hr = 0; ld_mt = 0; ld_sc = 0; al_hr = 0; al_mt = 0;
    cyc(2);
    chk_on = 1;
    lit("reset_sc", SC, 0); lit("reset_hr", HR, 0); lit("reset_tick", tick, 0);

    // free run: tick every 4th cycle
    rst_n = 1; en = 1; nt = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); nt += tick; end
    lit("run_ticks", nt, 3); lit("run_sc", SC, 3); lit("run_mt", MT, 0); lit("run_hr", HR, 0);

    // midnight rollover
    do_load(23, 59, 58);
    cyc(4);
    lit("pre_wrap_sc", SC, 59); lit("pre_wrap_hr", HR, 23); lit("pre_wrap_pm", pm, 1);
    cyc(4);
    lit("wrap_sc", SC, 0); lit("wrap_mt", MT, 0); lit("wrap_hr", HR, 0);
    lit("wrap_tc", tc, 1); lit("wrap_pm", pm, 0);
    cyc(1);
    lit("wrap_tc_off", tc, 0);

    // display mode toggle
    en = 0;
    do_load(13, 5, 0);
    lit("m24_hr", HR, 13); lit("m24_pm", pm, 1);
    mode24 = 0; #1;
    lit("m12_hr", HR, 1); lit("m12_pm", pm, 1); lit("m12_mt", MT, 5);
    mode24 = 1; #1;
    lit("m24b_hr", HR, 13); lit("m24b_sc", SC, 0);
    cyc(1);

    // alarm by tick, not by load
    alarm_en = 1; al_hr = 7; al_mt = 30; en = 1;
    do_load(7, 29, 59);
    cyc(3); lit("alarm_early", alarm, 0);
    cyc(1);
    lit("alarm_hit", alarm, 1); lit("alarm_mt", MT, 30); lit("alarm_hr", HR, 7);
    cyc(1); lit("alarm_once", alarm, 0);
    do_load(7, 30, 0);
    lit("alarm_load", alarm, 0);
    cyc(1); lit("alarm_load2", alarm, 0);
    en = 0; alarm_en = 0;

    // out-of-range preset
    do_load(24, 12, 60);
    lit("lerr_pulse", load_err, 1); lit("lerr_sc", SC, 0);
    lit("lerr_mt", MT, 12); lit("lerr_hr", HR, 0);
    cyc(1); lit("lerr_off", load_err, 0);

    // freeze, load over a tick, then reset
    en = 1; cyc(2);
    en = 0; cyc(10);
    lit("freeze_sc", SC, 0); lit("freeze_mt", MT, 12);
    en = 1; cyc(1);
    do_load(1, 2, 3);
    lit("ldtick_tick", tick, 0); lit("ldtick_sc", SC, 3);
    lit("ldtick_mt", MT, 2); lit("ldtick_hr", HR, 1);
    cyc(2);
    rst_n = 0; cyc(1);
    lit("rst_sc", SC, 0); lit("rst_mt", MT, 0); lit("rst_hr", HR, 0); lit("rst_tick", tick, 0);
    rst_n = 1; cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
